// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI word receiver.
package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    localparam int SPI_WORD_W     = 8;
    localparam int SPI_FIFO_DEPTH = 4;

    // Synchronizer flop reset value, bit order {in_clk, cs, sdi}: cs idles high.
    localparam logic [2:0] SYNC_RST = 3'b010;

endpackage

// File: rtl/spi_rx_fifo.sv
// Small FIFO with a registered head word; pointers carry one extra bit
// so full and empty can be told apart when the indices match.
module spi_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_nxt;
    logic [AW:0]      rd_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign wr_nxt  = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_nxt  = rd_ptr + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // The head register takes the incoming word directly when it becomes the head.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pop_data <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            if (wr_nxt != rd_nxt) begin
                pop_data <= (do_push && (rd_nxt == wr_ptr)) ? push_data : mem[rd_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/spi_word_rx.sv
// Oversampling SPI word receiver: synchronizes in_clk/cs/sdi, deserializes
// MSB-first words into a FIFO and reports frame status.
module spi_word_rx
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WORD_W,
    parameter int DEPTH = SPI_FIFO_DEPTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             in_clk,
    input  logic             cs,
    input  logic             sdi,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_end,
    output logic             frame_err,
    output logic             overflow,
    input  logic             ovf_clear,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int BW = $clog2(WIDTH + 1);

    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic             in_clk_s1;
    logic             in_clk_s2;
    logic             cs_s2;
    logic             sdi_s2;
    logic             rise;

    spi_state_e       state;
    spi_state_e       state_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             push_word;
    logic             end_nxt;
    logic             err_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
        end else begin
            sync1 <= {in_clk, cs, sdi};
            sync2 <= sync1;
        end
    end

    assign in_clk_s1 = sync1[2];
    assign in_clk_s2 = sync2[2];
    assign cs_s2     = sync2[1];
    assign sdi_s2    = sync2[0];
    assign rise      = in_clk_s1 && !in_clk_s2;

    // A rise in the same cycle as cs going high is shifted in before the frame closes.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        cnt_nxt     = word_cnt;
        push_word   = 1'b0;
        end_nxt     = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cs_s2) begin
                    state_nxt   = ST_ACTIVE;
                    bit_cnt_nxt = '0;
                    shift_nxt   = '0;
                    cnt_nxt     = '0;
                end
            end
            ST_ACTIVE: begin
                if (rise) begin
                    shift_nxt = {shift_reg[WIDTH-2:0], sdi_s2};
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        push_word   = 1'b1;
                        bit_cnt_nxt = '0;
                        if (word_cnt != '1) begin
                            cnt_nxt = word_cnt + 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
                if (cs_s2) begin
                    state_nxt = ST_IDLE;
                    end_nxt   = 1'b1;
                    err_nxt   = (bit_cnt_nxt != '0);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign drop = push_word && fifo_full && !(out_valid && out_ready);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            word_cnt  <= '0;
            frame_end <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            word_cnt  <= cnt_nxt;
            frame_end <= end_nxt;
            frame_err <= err_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    spi_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nreset    (nreset),
        .push      (push_word),
        .push_data (shift_nxt),
        .full      (fifo_full),
        .pop       (out_ready),
        .pop_data  (out_data),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;

endmodule
